// File: rtl/msg_pkg.sv
// +----------------------------------------------------------------------------+
// | Module  : msg_pkg                                                          |
// | Brief   : Message field layout, widths and opcode constants.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package msg_pkg;

    localparam int unsigned c_opc_w     = 4;
    localparam int unsigned c_bcast_bit = 3;

    localparam logic [3:0] c_opc_read  = 4'h1;
    localparam logic [3:0] c_opc_write = 4'h2;
    localparam logic [3:0] c_opc_snoop = 4'h8;
    localparam logic [3:0] c_opc_inval = 4'h9;

    localparam int unsigned c_def_cache_num  = 2;
    localparam int unsigned c_def_addr_width = 32;
    localparam int unsigned c_def_id_w       = $clog2(c_def_cache_num);

    function automatic int unsigned id_w(input int unsigned cache_num);
        return (cache_num < 2) ? 1 : $clog2(cache_num);
    endfunction

    function automatic int unsigned msg_w(input int unsigned cache_num,
                                          input int unsigned addr_width);
        return c_opc_w + 2 * id_w(cache_num) + addr_width;
    endfunction

    // Layout from LSB: addr, dst_id, src_id, opcode.
    function automatic int unsigned dst_lsb(input int unsigned addr_width);
        return addr_width;
    endfunction

    function automatic int unsigned src_lsb(input int unsigned cache_num,
                                            input int unsigned addr_width);
        return addr_width + id_w(cache_num);
    endfunction

    function automatic int unsigned opc_lsb(input int unsigned cache_num,
                                            input int unsigned addr_width);
        return addr_width + 2 * id_w(cache_num);
    endfunction

    typedef struct packed {
        logic [c_opc_w-1:0]          opcode;
        logic [c_def_id_w-1:0]       src_id;
        logic [c_def_id_w-1:0]       dst_id;
        logic [c_def_addr_width-1:0] addr;
    } msg_t;

endpackage

`default_nettype wire

// File: rtl/msg_fifo.sv
// +----------------------------------------------------------------------------+
// | Module  : msg_fifo                                                         |
// | Brief   : Synchronous FIFO, registered storage, no fall-through.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module msg_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_pop_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_pop_data = r_mem[r_rd_ptr];

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage carries no reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/msg_dispatch.sv
// +----------------------------------------------------------------------------+
// | Module  : msg_dispatch                                                     |
// | Brief   : Buffers arbitrated messages and delivers them to target caches.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module msg_dispatch
    import msg_pkg::*;
#(
    parameter  int unsigned CACHE_NUM  = 2,
    parameter  int unsigned ADDR_WIDTH = 32,
    parameter  int unsigned FIFO_DEPTH = 4,
    localparam int unsigned ID_W       = id_w(CACHE_NUM),
    localparam int unsigned MSG_W      = msg_w(CACHE_NUM, ADDR_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 msg_in_valid,
    input  logic [MSG_W-1:0]     msg_in,
    output logic                 msg_in_ready,
    output logic [CACHE_NUM-1:0] deliv_valid,
    input  logic [CACHE_NUM-1:0] deliv_ready,
    output logic [MSG_W-1:0]     deliv_msg,
    output logic                 busy,
    input  logic                 err_clr,
    output logic                 err_ovf,
    output logic                 err_dst
);

    localparam int unsigned DST_LSB = dst_lsb(ADDR_WIDTH);
    localparam int unsigned SRC_LSB = src_lsb(CACHE_NUM, ADDR_WIDTH);
    localparam int unsigned OPC_LSB = opc_lsb(CACHE_NUM, ADDR_WIDTH);
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);

    localparam logic [0:0] c_st_idle    = 1'b0;
    localparam logic [0:0] c_st_deliver = 1'b1;

    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic [MSG_W-1:0]     r_hold;
    logic [MSG_W-1:0]     w_hold_nxt;
    logic [CACHE_NUM-1:0] r_pending;
    logic [CACHE_NUM-1:0] w_pending_nxt;
    logic                 r_err_ovf;
    logic                 r_err_dst;

    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [CNT_W-1:0]     w_fifo_count;
    logic [MSG_W-1:0]     w_head;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_ovf_evt;
    logic                 w_dst_evt;

    logic                 w_head_bcast;
    logic [ID_W-1:0]      w_head_dst;
    logic [ID_W-1:0]      w_head_src;
    logic [CACHE_NUM-1:0] w_dst_hot;
    logic [CACHE_NUM-1:0] w_src_hot;
    logic [CACHE_NUM-1:0] w_head_mask;
    logic [CACHE_NUM-1:0] w_remaining;
    logic                 w_slot_free;

    assign w_push    = msg_in_valid && !w_fifo_full;
    assign w_ovf_evt = msg_in_valid && w_fifo_full;

    msg_fifo #(
        .WIDTH (MSG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (msg_in),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    assign w_head_bcast = w_head[OPC_LSB + c_bcast_bit];
    assign w_head_dst   = w_head[DST_LSB +: ID_W];
    assign w_head_src   = w_head[SRC_LSB +: ID_W];

    // An out-of-range dst_id decodes to an all-zero mask, which is how bad targets are caught.
    for (genvar i = 0; i < CACHE_NUM; i++) begin : g_mask
        assign w_dst_hot[i] = (w_head_dst == ID_W'(i));
        assign w_src_hot[i] = (w_head_src == ID_W'(i));
    end

    assign w_head_mask = w_head_bcast ? ~w_src_hot : w_dst_hot;

    always_comb begin
        w_remaining   = r_pending & ~deliv_ready;
        w_slot_free   = (r_state == c_st_idle) || (w_remaining == '0);
        w_pop         = w_slot_free && !w_fifo_empty;
        w_state_nxt   = r_state;
        w_hold_nxt    = r_hold;
        w_pending_nxt = w_remaining;
        w_dst_evt     = 1'b0;

        if (w_pop) begin
            if (w_head_mask != '0) begin
                w_hold_nxt    = w_head;
                w_pending_nxt = w_head_mask;
                w_state_nxt   = c_st_deliver;
            end else begin
                w_dst_evt     = 1'b1;
                w_pending_nxt = '0;
                w_state_nxt   = c_st_idle;
            end
        end else if ((r_state == c_st_deliver) && (w_remaining == '0)) begin
            w_state_nxt = c_st_idle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A new error event in the same cycle as err_clr leaves the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold    <= '0;
            r_pending <= '0;
            r_err_ovf <= 1'b0;
            r_err_dst <= 1'b0;
        end else begin
            r_hold    <= w_hold_nxt;
            r_pending <= w_pending_nxt;
            r_err_ovf <= w_ovf_evt | (r_err_ovf & ~err_clr);
            r_err_dst <= w_dst_evt | (r_err_dst & ~err_clr);
        end
    end

    assign msg_in_ready = !w_fifo_full;
    assign deliv_valid  = r_pending;
    assign deliv_msg    = r_hold;
    assign busy         = (r_state == c_st_deliver) || (w_fifo_count != '0);
    assign err_ovf      = r_err_ovf;
    assign err_dst      = r_err_dst;

endmodule

`default_nettype wire

// File: tb/tb_msg_dispatch.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_msg_dispatch                                                  |
// | Brief   : Scoreboard bench for msg_dispatch (4-cache and 3-cache builds).  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_msg_dispatch;
    import msg_pkg::*;

    localparam int unsigned MW = 40;

    typedef struct {
        logic [3:0]    mask;
        logic [MW-1:0] msg;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;

    logic          vin4 = 1'b0;
    logic [MW-1:0] min4 = '0;
    logic          rdy4;
    logic [3:0]    dv4;
    logic [3:0]    dr4;
    logic [MW-1:0] dm4;
    logic          busy4;
    logic          clr4 = 1'b0;
    logic          eo4;
    logic          ed4;
    logic [3:0]    dr_dir = '0;
    logic [3:0]    dr_rnd = '0;
    logic          rnd_on = 1'b0;

    logic          vin3 = 1'b0;
    logic [MW-1:0] min3 = '0;
    logic          rdy3;
    logic [2:0]    dv3;
    logic [2:0]    dr3 = '0;
    logic [MW-1:0] dm3;
    logic          busy3;
    logic          clr3 = 1'b0;
    logic          eo3;
    logic          ed3;

    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    exp_t          exp_q[$];
    int            starts[$];
    logic [3:0]    cur_mask = '0;
    logic [MW-1:0] cur_msg = '0;

    assign dr4 = rnd_on ? dr_rnd : dr_dir;

    msg_dispatch #(.CACHE_NUM(4), .ADDR_WIDTH(32), .FIFO_DEPTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .msg_in_valid(vin4), .msg_in(min4), .msg_in_ready(rdy4),
        .deliv_valid(dv4), .deliv_ready(dr4), .deliv_msg(dm4), .busy(busy4),
        .err_clr(clr4), .err_ovf(eo4), .err_dst(ed4)
    );

    msg_dispatch #(.CACHE_NUM(3), .ADDR_WIDTH(32), .FIFO_DEPTH(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .msg_in_valid(vin3), .msg_in(min3), .msg_in_ready(rdy3),
        .deliv_valid(dv3), .deliv_ready(dr3), .deliv_msg(dm3), .busy(busy3),
        .err_clr(clr3), .err_ovf(eo3), .err_dst(ed3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            dr_rnd = 4'($urandom);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [MW-1:0] mk(input logic [3:0] op, input int src, input int dst,
                                         input logic [31:0] addr);
        logic [1:0] s;
        logic [1:0] d;
        s = 2'(src);
        d = 2'(dst);
        return {op, s, d, addr};
    endfunction

    function automatic logic [3:0] hot(input int idx);
        logic [3:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: matches each new delivery against the head of the expected queue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            cur_mask = '0;
        end else if (dv4 != '0 || cur_mask != '0) begin
            if (cur_mask == '0) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected", {60'd0, dv4}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_mask", {60'd0, dv4}, {60'd0, e.mask});
                    chk("sb_msg", {24'd0, dm4}, {24'd0, e.msg});
                    cur_mask = e.mask;
                    cur_msg  = e.msg;
                    starts.push_back(cyc);
                end
            end else begin
                chk("sb_pending", {60'd0, dv4}, {60'd0, cur_mask});
                chk("sb_stable", {24'd0, dm4}, {24'd0, cur_msg});
            end
            cur_mask = cur_mask & ~dr4;
        end
    end

    task automatic send4(input logic [3:0] op, input int src, input int dst,
                         input logic [31:0] addr, input logic [3:0] emask);
        int n;
        exp_t e;
        n = 0;
        while (!rdy4 && n < 500) begin
            tick();
            n++;
        end
        chk("send_ready", {63'd0, rdy4}, 64'd1);
        min4 = mk(op, src, dst, addr);
        vin4 = 1'b1;
        if (emask != '0) begin
            e.mask = emask;
            e.msg  = min4;
            exp_q.push_back(e);
        end
        tick();
        vin4 = 1'b0;
    endtask

    task automatic wait_idle4();
        int n;
        n = 0;
        while ((busy4 || cur_mask != '0 || exp_q.size() != 0) && n < 1000) begin
            tick();
            n++;
        end
        chk("drain_queue", 64'(exp_q.size()), 64'd0);
        chk("drain_busy", {63'd0, busy4}, 64'd0);
    endtask

    initial begin
        logic [MW-1:0] m;
        logic [2:0]    seen;
        logic [MW-1:0] got;

        // Reset state
        tick();
        tick();
        chk("rst_dv", {60'd0, dv4}, 64'd0);
        chk("rst_ready", {63'd0, rdy4}, 64'd1);
        chk("rst_busy", {63'd0, busy4}, 64'd0);
        chk("rst_err", {62'd0, eo4, ed4}, 64'd0);
        chk("rst_msg", {24'd0, dm4}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Unicast latency: push at edge N, valid after N+1
        dr_dir = 4'b0000;
        send4(c_opc_read, 0, 2, 32'h1000, 4'b0100);
        chk("lat_n", {60'd0, dv4}, 64'd0);
        tick();
        chk("lat_n1", {60'd0, dv4}, 64'b0100);
        dr_dir = 4'b0100;
        tick();
        chk("uni_pop", {60'd0, dv4}, 64'd0);
        wait_idle4();

        // Back-to-back unicast with ready held high
        dr_dir = 4'b1111;
        starts.delete();
        for (int k = 0; k < 4; k++) begin
            send4(c_opc_write, k, (k + 3) % 4, 32'h1100 + 32'(k), hot((k + 3) % 4));
        end
        wait_idle4();
        chk("b2b_count", 64'(starts.size()), 64'd4);
        if (starts.size() == 4) chk("b2b_span", 64'(starts[3] - starts[0]), 64'd3);

        // Broadcast from src 1, caches accept one at a time
        dr_dir = 4'b0000;
        m = mk(c_opc_snoop, 1, 0, 32'h2000);
        send4(c_opc_snoop, 1, 0, 32'h2000, 4'b1101);
        tick();
        chk("bc_mask", {60'd0, dv4}, 64'b1101);
        chk("bc_msg", {24'd0, dm4}, {24'd0, m});
        dr_dir = 4'b0001;
        tick();
        dr_dir = 4'b0000;
        chk("bc_after0", {60'd0, dv4}, 64'b1100);
        dr_dir = 4'b1000;
        tick();
        dr_dir = 4'b0000;
        chk("bc_after3", {60'd0, dv4}, 64'b0100);
        chk("bc_msg_hold", {24'd0, dm4}, {24'd0, m});
        dr_dir = 4'b0100;
        tick();
        dr_dir = 4'b0000;
        chk("bc_done", {60'd0, dv4}, 64'd0);
        chk("bc_busy", {63'd0, busy4}, 64'd0);

        // Fill: one in holding register plus four buffered
        for (int k = 0; k < 5; k++) begin
            send4(c_opc_read, 0, k % 4, 32'h3000 + 32'(k), hot(k % 4));
        end
        chk("full_ready", {63'd0, rdy4}, 64'd0);
        chk("full_busy", {63'd0, busy4}, 64'd1);
        min4 = mk(c_opc_read, 0, 0, 32'hdead);
        vin4 = 1'b1;
        tick();
        vin4 = 1'b0;
        chk("ovf_flag", {63'd0, eo4}, 64'd1);
        chk("ovf_ready", {63'd0, rdy4}, 64'd0);
        dr_dir = 4'b1111;
        wait_idle4();
        chk("ovf_sticky", {63'd0, eo4}, 64'd1);
        clr4 = 1'b1;
        tick();
        clr4 = 1'b0;
        chk("ovf_clr", {63'd0, eo4}, 64'd0);

        // Bad destination on the 3-cache build
        dr3  = 3'b111;
        min3 = mk(c_opc_read, 0, 3, 32'h6000);
        vin3 = 1'b1;
        tick();
        m    = mk(c_opc_read, 2, 1, 32'h6100);
        min3 = m;
        tick();
        vin3 = 1'b0;
        seen = '0;
        got  = '0;
        for (int i = 0; i < 6; i++) begin
            seen = seen | dv3;
            if (dv3 != '0) got = dm3;
            tick();
        end
        chk("dst_seen", {61'd0, seen}, 64'b010);
        chk("dst_next_msg", {24'd0, got}, {24'd0, m});
        chk("dst_flag", {63'd0, ed3}, 64'd1);
        chk("dst_no_ovf", {63'd0, eo3}, 64'd0);
        clr3 = 1'b1;
        tick();
        clr3 = 1'b0;
        chk("dst_clr", {63'd0, ed3}, 64'd0);

        // Pointer wrap with random acceptance
        rnd_on = 1'b1;
        for (int k = 0; k < 13; k++) begin
            if (k % 3 == 2) begin
                send4(c_opc_inval, k % 4, 0, 32'h4000 + 32'(k * 16), 4'b1111 & ~hot(k % 4));
            end else begin
                send4(c_opc_read, 0, k % 4, 32'h4000 + 32'(k * 16), hot(k % 4));
            end
        end
        wait_idle4();
        rnd_on = 1'b0;
        chk("wrap_err", {62'd0, eo4, ed4}, 64'd0);

        // Asynchronous reset in the middle of a delivery
        dr_dir = 4'b0000;
        send4(c_opc_read, 0, 1, 32'h5000, 4'b0010);
        tick();
        chk("rst_pre_dv", {60'd0, dv4}, 64'b0010);
        for (int k = 0; k < 4; k++) begin
            send4(c_opc_read, 0, 3, 32'h5100 + 32'(k), 4'b1000);
        end
        vin4 = 1'b1;
        tick();
        vin4 = 1'b0;
        chk("rst_pre_ovf", {63'd0, eo4}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_dv", {60'd0, dv4}, 64'd0);
        chk("arst_ready", {63'd0, rdy4}, 64'd1);
        chk("arst_busy", {63'd0, busy4}, 64'd0);
        chk("arst_err", {62'd0, eo4, ed4}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_dv", {60'd0, dv4}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
